puf_eval_ctrl: RTL and testbench

Sequencing controller between the 16-bit UART challenge receiver, the 128-bit arbiter PUF and the 128-bit UART transmitter. It latches each received challenge and runs the PUF NEVAL times on it. It then sends the first response, followed by a 128-bit unstable-bit mask: the OR over all later evaluations of (response XOR first response). A check mode replaces both frames with a fixed test pattern and its inverse, giving a link self-test with no PUF activity.

---
 rtl/puf_eval_ctrl.sv | 217 +++++++++++++++++++++
 tb/tb_puf_eval_ctrl.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/puf_eval_ctrl.sv
// Sequencing controller: latches a UART challenge, runs the arbiter PUF NEVAL
// times, then sends the first response and an unstable-bit mask over UART.
// A check mode sends a fixed test pattern and its inverse with no PUF activity.
module puf_eval_ctrl #(
  parameter int unsigned  NEVAL        = 4,
  parameter int unsigned  TIMEOUT      = 4096,
  parameter logic [127:0] TEST_PATTERN = 128'hABCDEF9876543210ABCDEF9876543210
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         chal_valid_i,
  input  logic [15:0]  chal_data_i,
  input  logic         check_i,
  output logic         puf_start_o,
  output logic [15:0]  puf_challenge_o,
  input  logic         puf_done_i,
  input  logic [127:0] puf_response_i,
  output logic         tx_start_o,
  output logic [127:0] tx_data_o,
  input  logic         tx_done_i,
  output logic         busy_o,
  output logic [3:0]   eval_count_o,
  output logic         err_timeout_o,
  output logic         err_overrun_o
);

  localparam int unsigned TW      = $clog2(TIMEOUT);
  localparam logic [TW-1:0] TmoLast = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] TmoOne  = TW'(1);
  localparam logic [3:0]    NevalC  = 4'(NEVAL);

  localparam logic [2:0] StIdle     = 3'd0;
  localparam logic [2:0] StEval     = 3'd1;
  localparam logic [2:0] StGap      = 3'd2;
  localparam logic [2:0] StTxResp   = 3'd3;
  localparam logic [2:0] StWaitResp = 3'd4;
  localparam logic [2:0] StTxMask   = 3'd5;
  localparam logic [2:0] StWaitMask = 3'd6;

  logic [2:0]    state_q, state_d;
  logic          puf_start_q, puf_start_d;
  logic [15:0]   chal_q, chal_d;
  logic          mode_q, mode_d;
  logic [3:0]    eval_cnt_q, eval_cnt_d;
  logic [127:0]  first_q, first_d;
  logic [127:0]  mask_q, mask_d;
  logic          tx_start_q, tx_start_d;
  logic [127:0]  tx_data_q, tx_data_d;
  logic          tx_done_prev_q;
  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic          err_tmo_q, err_tmo_d;
  logic          err_ovr_q, err_ovr_d;

  logic tx_rise;
  logic tmo_hit;

  assign tx_rise = tx_done_i & ~tx_done_prev_q;
  assign tmo_hit = (tmo_cnt_q == TmoLast);

  // Next-state logic; in wait states the exit condition is tested before expiry.
  always_comb begin
    state_d     = state_q;
    puf_start_d = puf_start_q;
    chal_d      = chal_q;
    mode_d      = mode_q;
    eval_cnt_d  = eval_cnt_q;
    first_d     = first_q;
    mask_d      = mask_q;
    tx_start_d  = 1'b0;
    tx_data_d   = tx_data_q;
    tmo_cnt_d   = tmo_cnt_q;
    err_tmo_d   = err_tmo_q;
    err_ovr_d   = err_ovr_q;

    if (chal_valid_i && (state_q != StIdle)) begin
      err_ovr_d = 1'b1;
    end

    case (state_q)
      StIdle: begin
        if (chal_valid_i) begin
          chal_d     = chal_data_i;
          mode_d     = check_i;
          eval_cnt_d = '0;
          mask_d     = '0;
          tmo_cnt_d  = '0;
          if (check_i) begin
            state_d = StTxResp;
          end else begin
            state_d     = StEval;
            puf_start_d = 1'b1;
          end
        end
      end
      StEval: begin
        if (puf_done_i) begin
          if (eval_cnt_q == 4'd0) begin
            first_d = puf_response_i;
          end else begin
            mask_d = mask_q | (puf_response_i ^ first_q);
          end
          if (eval_cnt_q < NevalC) begin
            eval_cnt_d = eval_cnt_q + 4'd1;
          end
          puf_start_d = 1'b0;
          tmo_cnt_d   = '0;
          state_d     = StGap;
        end else if (tmo_hit) begin
          puf_start_d = 1'b0;
          err_tmo_d   = 1'b1;
          state_d     = StIdle;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TmoOne;
        end
      end
      StGap: begin
        if (!puf_done_i) begin
          if (eval_cnt_q < NevalC) begin
            puf_start_d = 1'b1;
            tmo_cnt_d   = '0;
            state_d     = StEval;
          end else begin
            state_d = StTxResp;
          end
        end else if (tmo_hit) begin
          err_tmo_d = 1'b1;
          state_d   = StIdle;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TmoOne;
        end
      end
      StTxResp: begin
        tx_data_d  = mode_q ? TEST_PATTERN : first_q;
        tx_start_d = 1'b1;
        tmo_cnt_d  = '0;
        state_d    = StWaitResp;
      end
      StWaitResp: begin
        if (tx_rise) begin
          state_d = StTxMask;
        end else if (tmo_hit) begin
          err_tmo_d = 1'b1;
          state_d   = StIdle;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TmoOne;
        end
      end
      StTxMask: begin
        tx_data_d  = mode_q ? ~TEST_PATTERN : mask_q;
        tx_start_d = 1'b1;
        tmo_cnt_d  = '0;
        state_d    = StWaitMask;
      end
      StWaitMask: begin
        if (tx_rise) begin
          state_d = StIdle;
        end else if (tmo_hit) begin
          err_tmo_d = 1'b1;
          state_d   = StIdle;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TmoOne;
        end
      end
      default: begin
        puf_start_d = 1'b0;
        state_d     = StIdle;
      end
    endcase
  end

  // State registers; the tx_done history resets high so a level held across
  // reset release is not mistaken for a completed frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= StIdle;
      puf_start_q    <= 1'b0;
      chal_q         <= '0;
      mode_q         <= 1'b0;
      eval_cnt_q     <= '0;
      first_q        <= '0;
      mask_q         <= '0;
      tx_start_q     <= 1'b0;
      tx_data_q      <= '0;
      tx_done_prev_q <= 1'b1;
      tmo_cnt_q      <= '0;
      err_tmo_q      <= 1'b0;
      err_ovr_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      puf_start_q    <= puf_start_d;
      chal_q         <= chal_d;
      mode_q         <= mode_d;
      eval_cnt_q     <= eval_cnt_d;
      first_q        <= first_d;
      mask_q         <= mask_d;
      tx_start_q     <= tx_start_d;
      tx_data_q      <= tx_data_d;
      tx_done_prev_q <= tx_done_i;
      tmo_cnt_q      <= tmo_cnt_d;
      err_tmo_q      <= err_tmo_d;
      err_ovr_q      <= err_ovr_d;
    end
  end

  // Strobes are gated by rst_n so they fall combinationally on reset assertion.
  always_comb begin
    puf_start_o     = puf_start_q & rst_n;
    tx_start_o      = tx_start_q & rst_n;
    puf_challenge_o = chal_q;
    tx_data_o       = tx_data_q;
    busy_o          = (state_q != StIdle);
    eval_count_o    = eval_cnt_q;
    err_timeout_o   = err_tmo_q;
    err_overrun_o   = err_ovr_q;
  end

endmodule

// File: tb/tb_puf_eval_ctrl.sv
// Self-checking bench for puf_eval_ctrl: acts as PUF and UART transmitter,
// predicts both frames from the list of responses it hands out.
module tb_puf_eval_ctrl;

  localparam int unsigned  NEVAL   = 4;
  localparam int unsigned  TIMEOUT = 16;
  localparam logic [127:0] TP      = 128'hABCDEF9876543210ABCDEF9876543210;
  localparam logic [127:0] TP_INV  = 128'h5432106789ABCDEF5432106789ABCDEF;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         chal_valid = 1'b0;
  logic [15:0]  chal_data = '0;
  logic         check = 1'b0;
  logic         puf_start;
  logic [15:0]  puf_challenge;
  logic         puf_done = 1'b0;
  logic [127:0] puf_response = '0;
  logic         tx_start;
  logic [127:0] tx_data;
  logic         tx_done = 1'b0;
  logic         busy;
  logic [3:0]   eval_count;
  logic         err_timeout;
  logic         err_overrun;

  int checks = 0;
  int errors = 0;
  logic [127:0] resp [NEVAL];

  puf_eval_ctrl #(
    .NEVAL       (NEVAL),
    .TIMEOUT     (TIMEOUT),
    .TEST_PATTERN(TP)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .chal_valid_i   (chal_valid),
    .chal_data_i    (chal_data),
    .check_i        (check),
    .puf_start_o    (puf_start),
    .puf_challenge_o(puf_challenge),
    .puf_done_i     (puf_done),
    .puf_response_i (puf_response),
    .tx_start_o     (tx_start),
    .tx_data_o      (tx_data),
    .tx_done_i      (tx_done),
    .busy_o         (busy),
    .eval_count_o   (eval_count),
    .err_timeout_o  (err_timeout),
    .err_overrun_o  (err_overrun)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic wait_puf_start(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (puf_start) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic wait_tx_start(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (tx_start) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  // One full transaction; frames predicted from resp[] (or the test pattern).
  task automatic run_txn(input logic [15:0] chal, input bit chk, input bit inject);
    logic [127:0] f1, f2;
    bit ok;
    if (chk) begin
      f1 = TP;
      f2 = TP_INV;
    end else begin
      f1 = resp[0];
      f2 = '0;
      for (int i = 1; i < NEVAL; i++) f2 = f2 | (resp[i] ^ resp[0]);
    end
    @(negedge clk);
    chal_valid = 1'b1;
    chal_data  = chal;
    check      = chk;
    @(negedge clk);
    chal_valid = 1'b0;
    check      = 1'b0;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL accept_busy got %b want 1", busy); end
    checks++;
    if (puf_start !== !chk) begin
      errors++; $display("FAIL start_latency got %b want %b", puf_start, !chk);
    end
    if (!chk) begin
      checks++;
      if (puf_challenge !== chal) begin
        errors++; $display("FAIL challenge got %h want %h", puf_challenge, chal);
      end
      for (int i = 0; i < NEVAL; i++) begin
        wait_puf_start(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL puf_start_wait got 0 want 1"); end
        repeat ($urandom_range(0, 5)) @(negedge clk);
        puf_response = resp[i];
        puf_done     = 1'b1;
        @(negedge clk);
        checks++;
        if ({puf_start, eval_count} !== {1'b0, 4'(i + 1)}) begin
          errors++;
          $display("FAIL eval_step got start=%b cnt=%0d want start=0 cnt=%0d",
                   puf_start, eval_count, i + 1);
        end
        repeat ($urandom_range(0, 5)) @(negedge clk);
        puf_done     = 1'b0;
        puf_response = rand128();
        if (i == NEVAL - 1) begin
          @(negedge clk);
          checks++;
          if (tx_start !== 1'b0) begin errors++; $display("FAIL tx_lat1 got %b want 0", tx_start); end
          @(negedge clk);
          checks++;
          if (tx_start !== 1'b1) begin errors++; $display("FAIL tx_lat2 got %b want 1", tx_start); end
        end
      end
    end
    wait_tx_start(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL tx1_wait got 0 want 1"); end
    checks++;
    if (tx_data !== f1) begin errors++; $display("FAIL frame1 got %h want %h", tx_data, f1); end
    if (inject) begin
      chal_valid = 1'b1;
      chal_data  = 16'hAAAA;
    end
    @(negedge clk);
    chal_valid = 1'b0;
    checks++;
    if (tx_start !== 1'b0) begin errors++; $display("FAIL tx1_pulse got %b want 0", tx_start); end
    if (inject) begin
      checks++;
      if (err_overrun !== 1'b1) begin errors++; $display("FAIL overrun got %b want 1", err_overrun); end
      checks++;
      if (puf_challenge !== chal) begin
        errors++; $display("FAIL overrun_chal got %h want %h", puf_challenge, chal);
      end
    end
    repeat ($urandom_range(0, 5)) @(negedge clk);
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
    wait_tx_start(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL tx2_wait got 0 want 1"); end
    checks++;
    if (tx_data !== f2) begin errors++; $display("FAIL frame2 got %h want %h", tx_data, f2); end
    repeat ($urandom_range(0, 5)) @(negedge clk);
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL done_busy got %b want 0", busy); end
    checks++;
    if (eval_count !== (chk ? 4'd0 : 4'(NEVAL))) begin
      errors++; $display("FAIL final_count got %0d want %0d", eval_count, chk ? 0 : NEVAL);
    end
    @(negedge clk);
    checks++;
    if (tx_data !== f2) begin errors++; $display("FAIL tx_hold got %h want %h", tx_data, f2); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({puf_start, tx_start, busy, err_timeout, err_overrun, eval_count, puf_challenge, tx_data}
        !== '0) begin
      errors++; $display("FAIL reset_outputs got nonzero want 0 (busy=%b)", busy);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({busy, tx_start} !== 2'b00) begin errors++; $display("FAIL post_release got %b want 00", {busy, tx_start}); end
  endtask

  task automatic test_constant_resp();
    for (int i = 0; i < NEVAL; i++) resp[i] = 128'h5;
    run_txn(16'h1234, 1'b0, 1'b0);
  endtask

  task automatic test_mask();
    resp[0] = 128'hF0; resp[1] = 128'hF1; resp[2] = 128'hB0; resp[3] = 128'hF0;
    run_txn(16'h0F0F, 1'b0, 1'b0);
  endtask

  task automatic test_check_mode();
    run_txn(16'h7777, 1'b1, 1'b0);
  endtask

  task automatic test_random();
    logic [127:0] base;
    for (int t = 0; t < 5; t++) begin
      base = rand128();
      resp[0] = base;
      for (int i = 1; i < NEVAL; i++) resp[i] = base ^ (rand128() & rand128() & rand128());
      run_txn(16'($urandom()), 1'b0, 1'b0);
    end
  endtask

  task automatic test_overrun();
    for (int i = 0; i < NEVAL; i++) resp[i] = rand128();
    run_txn(16'h1234, 1'b0, 1'b1);
  endtask

  task automatic test_timeout();
    int  n;
    bit  tx_seen;
    @(negedge clk);
    chal_valid = 1'b1;
    chal_data  = 16'h0BAD;
    @(negedge clk);
    chal_valid = 1'b0;
    n = 0;
    tx_seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (!busy) break;
      if (puf_start) n++;
      if (tx_start) tx_seen = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (n != TIMEOUT) begin errors++; $display("FAIL timeout_len got %0d want %0d", n, TIMEOUT); end
    checks++;
    if (err_timeout !== 1'b1) begin errors++; $display("FAIL err_timeout got %b want 1", err_timeout); end
    checks++;
    if ({tx_seen, busy, puf_start} !== 3'b000) begin
      errors++; $display("FAIL timeout_quiet got %b want 000", {tx_seen, busy, puf_start});
    end
    for (int i = 0; i < NEVAL; i++) resp[i] = rand128();
    run_txn(16'h4321, 1'b0, 1'b0);
    checks++;
    if (err_timeout !== 1'b1) begin errors++; $display("FAIL timeout_sticky got %b want 1", err_timeout); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    bit bad;
    @(negedge clk);
    chal_valid = 1'b1;
    chal_data  = 16'h5A5A;
    @(negedge clk);
    chal_valid = 1'b0;
    wait_puf_start(ok);
    tx_done = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({puf_start, tx_start, busy, err_timeout, err_overrun, eval_count, puf_challenge, tx_data}
        !== '0) begin
      errors++; $display("FAIL async_reset got start=%b busy=%b errs=%b want all 0",
                         puf_start, busy, {err_timeout, err_overrun});
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chal_valid = 1'b1;
    chal_data  = 16'h0001;
    check      = 1'b1;
    @(negedge clk);
    chal_valid = 1'b0;
    check      = 1'b0;
    wait_tx_start(ok);
    checks++;
    if (tx_data !== TP) begin errors++; $display("FAIL rst_frame1 got %h want %h", tx_data, TP); end
    bad = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if ({tx_start, busy} !== 2'b01) bad = 1'b1;
    end
    checks++;
    if (bad) begin errors++; $display("FAIL held_done_no_edge got edge want none"); end
    tx_done = 1'b0;
    @(negedge clk);
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
    wait_tx_start(ok);
    checks++;
    if (tx_data !== TP_INV) begin errors++; $display("FAIL rst_frame2 got %h want %h", tx_data, TP_INV); end
    @(negedge clk);
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL rst_done_busy got %b want 0", busy); end
  endtask

  initial begin
    test_reset();
    test_constant_resp();
    test_mask();
    test_check_mode();
    test_random();
    test_overrun();
    test_timeout();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
